// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - shared raster timing constants, widths and decode helpers
package vtg_pkg;

   localparam int VTG_CLK_DIV   = 8;
   localparam int VTG_H_TOTAL   = 384;
   localparam int VTG_H_VISIBLE = 256;
   localparam int VTG_HS_START  = 304;
   localparam int VTG_HS_WIDTH  = 32;
   localparam int VTG_V_TOTAL   = 262;
   localparam int VTG_V_VISIBLE = 232;
   localparam int VTG_VS_START  = 244;
   localparam int VTG_VS_WIDTH  = 3;

   localparam int HOFS_W = 4;
   localparam int VOFS_W = 3;
   localparam int CNT_W  = 9;
   localparam int CMP_W  = 10;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [CMP_W-1:0] cmp_t;

   typedef struct packed {
      logic hblk;
      logic vblk;
      logic hs;
      logic vs;
   } vtg_flags_t;

   function automatic cmp_t sext_hofs(input logic [HOFS_W-1:0] ofs);
      return {{(CMP_W-HOFS_W){ofs[HOFS_W-1]}}, ofs};
   endfunction

   function automatic cmp_t sext_vofs(input logic [VOFS_W-1:0] ofs);
      return {{(CMP_W-VOFS_W){ofs[VOFS_W-1]}}, ofs};
   endfunction

   // Start already includes the sign-extended offset, added modulo 2**CMP_W.
   function automatic logic in_window(input cnt_t pos, input cmp_t start, input cmp_t width);
      cmp_t p;
      p = cmp_t'(pos);
      return (p >= start) && (p < start + width);
   endfunction

endpackage

// File: rtl/vtg_div.sv
// rtl/vtg_div.sv - master clock divider producing the one-cycle pixel clock enable
module vtg_div #(
   parameter int CLK_DIV = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic pce_o
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          pce_q, pce_d;

   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      pce_d = (div_q == DIV_LAST);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         pce_q <= 1'b0;
      end else begin
         div_q <= div_d;
         pce_q <= pce_d;
      end
   end

   assign pce_o = pce_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters, per-frame sync offset latch and sync/blank decode
module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int CLK_DIV   = VTG_CLK_DIV,
   parameter int H_TOTAL   = VTG_H_TOTAL,
   parameter int H_VISIBLE = VTG_H_VISIBLE,
   parameter int HS_START  = VTG_HS_START,
   parameter int HS_WIDTH  = VTG_HS_WIDTH,
   parameter int V_TOTAL   = VTG_V_TOTAL,
   parameter int V_VISIBLE = VTG_V_VISIBLE,
   parameter int VS_START  = VTG_VS_START,
   parameter int VS_WIDTH  = VTG_VS_WIDTH
) (
   input  logic              MCLK,
   input  logic              RESET_N,
   input  logic [HOFS_W-1:0] HOFS,
   input  logic [VOFS_W-1:0] VOFS,
   output logic              PCE,
   output logic [CNT_W-1:0]  PH,
   output logic [CNT_W-1:0]  PV,
   output logic              HBLK,
   output logic              VBLK,
   output logic              HS,
   output logic              VS,
   output logic              FRAME
);

   localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_VIS   = cnt_t'(H_VISIBLE);
   localparam cnt_t V_VIS   = cnt_t'(V_VISIBLE);
   localparam cmp_t HS_BASE = cmp_t'(HS_START);
   localparam cmp_t HS_LEN  = cmp_t'(HS_WIDTH);
   localparam cmp_t VS_BASE = cmp_t'(VS_START);
   localparam cmp_t VS_LEN  = cmp_t'(VS_WIDTH);

   logic              pce;
   logic              h_wrap, v_wrap;
   cnt_t              ph_q, ph_d;
   cnt_t              pv_q, pv_d;
   logic [HOFS_W-1:0] hofs_q, hofs_d;
   logic [VOFS_W-1:0] vofs_q, vofs_d;
   vtg_flags_t        flags_q, flags_d;
   logic              frame_q, frame_d;

   vtg_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk_i  (MCLK),
      .rst_ni (RESET_N),
      .pce_o  (pce)
   );

   assign h_wrap = (ph_q == H_LAST);
   assign v_wrap = (pv_q == V_LAST);

   always_comb begin
      ph_d    = ph_q;
      pv_d    = pv_q;
      hofs_d  = hofs_q;
      vofs_d  = vofs_q;
      frame_d = 1'b0;
      if (pce) begin
         ph_d = h_wrap ? '0 : ph_q + 1'b1;
         if (h_wrap) begin
            pv_d = v_wrap ? '0 : pv_q + 1'b1;
         end
         // Offsets only move at the frame wrap so a frame never tears mid-scan.
         if (h_wrap && v_wrap) begin
            hofs_d  = HOFS;
            vofs_d  = VOFS;
            frame_d = 1'b1;
         end
      end
   end

   // Decoding the next-state counters keeps the flags on the same edge as PH/PV.
   always_comb begin
      flags_d      = '0;
      flags_d.hblk = (ph_d >= H_VIS);
      flags_d.vblk = (pv_d >= V_VIS);
      flags_d.hs   = in_window(ph_d, HS_BASE + sext_hofs(hofs_d), HS_LEN);
      flags_d.vs   = in_window(pv_d, VS_BASE + sext_vofs(vofs_d), VS_LEN);
   end

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ph_q    <= '0;
         pv_q    <= '0;
         hofs_q  <= '0;
         vofs_q  <= '0;
         flags_q <= '0;
         frame_q <= 1'b0;
      end else begin
         ph_q    <= ph_d;
         pv_q    <= pv_d;
         hofs_q  <= hofs_d;
         vofs_q  <= vofs_d;
         flags_q <= flags_d;
         frame_q <= frame_d;
      end
   end

   assign PCE   = pce;
   assign PH    = ph_q;
   assign PV    = pv_q;
   assign HBLK  = flags_q.hblk;
   assign VBLK  = flags_q.vblk;
   assign HS    = flags_q.hs;
   assign VS    = flags_q.vs;
   assign FRAME = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench over default, medium and tiny raster configurations
module tb_video_timing_gen;

   typedef struct {
      int          cyc;
      logic [23:0] v;
   } exp_t;

   logic       mclk;
   logic       rst_a, rst_b, rst_c, rst_sel;
   logic [3:0] hofs;
   logic [2:0] vofs;
   int         sel;

   logic       pce_a, hblk_a, vblk_a, hs_a, vs_a, frame_a;
   logic [8:0] ph_a, pv_a;
   logic       pce_b, hblk_b, vblk_b, hs_b, vs_b, frame_b;
   logic [8:0] ph_b, pv_b;
   logic       pce_c, hblk_c, vblk_c, hs_c, vs_c, frame_c;
   logic [8:0] ph_c, pv_c;

   logic [23:0] obs;
   int          cyc;
   exp_t        sbq[$];
   exp_t        e_m;
   int          n_vec, n_err;

   int p_d, p_h, p_hv, p_hs, p_hw, p_v, p_vv, p_vs, p_vw;
   int ho_f[4];
   int vo_f[4];

   video_timing_gen u_dut_a (
      .MCLK(mclk), .RESET_N(rst_a), .HOFS(hofs), .VOFS(vofs),
      .PCE(pce_a), .PH(ph_a), .PV(pv_a), .HBLK(hblk_a), .VBLK(vblk_a),
      .HS(hs_a), .VS(vs_a), .FRAME(frame_a)
   );

   video_timing_gen #(
      .CLK_DIV(3), .H_TOTAL(40), .H_VISIBLE(20), .HS_START(28), .HS_WIDTH(4),
      .V_TOTAL(20), .V_VISIBLE(8), .VS_START(12), .VS_WIDTH(2)
   ) u_dut_b (
      .MCLK(mclk), .RESET_N(rst_b), .HOFS(hofs), .VOFS(vofs),
      .PCE(pce_b), .PH(ph_b), .PV(pv_b), .HBLK(hblk_b), .VBLK(vblk_b),
      .HS(hs_b), .VS(vs_b), .FRAME(frame_b)
   );

   video_timing_gen #(
      .CLK_DIV(2), .H_TOTAL(8), .H_VISIBLE(6), .HS_START(6), .HS_WIDTH(1),
      .V_TOTAL(4), .V_VISIBLE(3), .VS_START(3), .VS_WIDTH(1)
   ) u_dut_c (
      .MCLK(mclk), .RESET_N(rst_c), .HOFS(hofs), .VOFS(vofs),
      .PCE(pce_c), .PH(ph_c), .PV(pv_c), .HBLK(hblk_c), .VBLK(vblk_c),
      .HS(hs_c), .VS(vs_c), .FRAME(frame_c)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   always_comb begin
      obs     = '0;
      rst_sel = rst_a;
      case (sel)
         0: begin
            obs     = {pce_a, frame_a, vs_a, hs_a, vblk_a, hblk_a, pv_a, ph_a};
            rst_sel = rst_a;
         end
         1: begin
            obs     = {pce_b, frame_b, vs_b, hs_b, vblk_b, hblk_b, pv_b, ph_b};
            rst_sel = rst_b;
         end
         default: begin
            obs     = {pce_c, frame_c, vs_c, hs_c, vblk_c, hblk_c, pv_c, ph_c};
            rst_sel = rst_c;
         end
      endcase
   end

   // MCLK edges since the selected DUT left reset
   always @(posedge mclk or negedge rst_sel) begin
      if (!rst_sel) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   function automatic logic [23:0] mk(input logic pce, input logic frm, input int ph, input int pv, input int f);
      int   hs0, vs0;
      logic hs, vs;
      hs0 = p_hs + ho_f[f];
      vs0 = p_vs + vo_f[f];
      hs  = (ph >= hs0) && (ph < hs0 + p_hw);
      vs  = (pv >= vs0) && (pv < vs0 + p_vw);
      return {pce, frm, vs, hs, (pv >= p_vv), (ph >= p_hv), 9'(pv), 9'(ph)};
   endfunction

   task automatic set_params(input int d, input int h, input int hv, input int hs, input int hw,
                             input int v, input int vv, input int vs, input int vw);
      p_d = d; p_h = h; p_hv = hv; p_hs = hs; p_hw = hw;
      p_v = v; p_vv = vv; p_vs = vs; p_vw = vw;
   endtask

   // Pixel k is on the outputs during its PCE pulse at cycle D*(k+1); FRAME follows each wrap pulse.
   task automatic push_run(input int npix);
      int   n;
      exp_t e;
      n = p_h * p_v;
      for (int k = 0; k < npix; k++) begin
         e.cyc = p_d * (k + 1);
         e.v   = mk(1'b1, 1'b0, k % p_h, (k / p_h) % p_v, k / n);
         sbq.push_back(e);
         if ((k + 1) % n == 0) begin
            e.cyc = p_d * (k + 1) + 1;
            e.v   = mk(1'b0, 1'b1, 0, 0, (k + 1) / n);
            sbq.push_back(e);
         end
      end
   endtask

   task automatic drain(input int limit, input string name);
      int t;
      t = 0;
      while (sbq.size() != 0 && t < limit) begin
         #1;
         t++;
      end
      if (sbq.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s timeout: %0d events outstanding, want 0", name, sbq.size());
         sbq.delete();
      end
   endtask

   task automatic check_now(input string name, input logic [23:0] got, input logic [23:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      sel   = 0;
      hofs  = 4'd0;
      vofs  = 3'd0;
      ho_f  = '{0, 0, 0, 0};
      vo_f  = '{0, 0, 0, 0};
      fork
         begin
            forever begin
               @(negedge mclk);
               if (obs[23] || obs[22]) begin
                  n_vec++;
                  if (sbq.size() == 0) begin
                     n_err++;
                     $display("FAIL unexpected_event sel=%0d cyc=%0d got %h", sel, cyc, obs);
                  end else begin
                     e_m = sbq.pop_front();
                     if (e_m.cyc != cyc || e_m.v !== obs) begin
                        n_err++;
                        $display("FAIL event sel=%0d cyc got %0d want %0d vec got %h want %h",
                                 sel, cyc, e_m.cyc, obs, e_m.v);
                     end
                  end
               end
            end
         end
         begin
            // default timing: PCE cadence, first line and wrap into line 1
            repeat (3) @(negedge mclk);
            check_now("reset_a", obs, 24'h0);
            set_params(8, 384, 256, 304, 32, 262, 232, 244, 3);
            push_run(400);
            @(negedge mclk);
            rst_a = 1'b1;
            drain(34000, "run_a");
            rst_a = 1'b0;

            // three frames, offsets changed mid-frame 0 and mid-frame 1
            sel = 1;
            repeat (2) @(negedge mclk);
            check_now("reset_b", obs, 24'h0);
            set_params(3, 40, 20, 28, 4, 20, 8, 12, 2);
            ho_f = '{0, -8, 7, 7};
            vo_f = '{0, 3, -4, -4};
            push_run(2400);
            @(negedge mclk);
            rst_b = 1'b1;
            repeat (1200) @(negedge mclk);
            hofs = 4'b1000;
            vofs = 3'd3;
            repeat (2400) @(negedge mclk);
            hofs = 4'd7;
            vofs = 3'b100;
            drain(40000, "frames_b");
            rst_b = 1'b0;

            // async reset at PH=30 PV=5 between pulses, then restart with offsets cleared
            ho_f = '{0, 0, 0, 0};
            vo_f = '{0, 0, 0, 0};
            push_run(230);
            repeat (2) @(negedge mclk);
            rst_b = 1'b1;
            drain(8000, "prereset_b");
            while (cyc < 692) @(negedge mclk);
            #2;
            check_now("pre_reset_b", obs, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd5, 9'd30});
            rst_b = 1'b0;
            #1;
            check_now("async_reset_b", obs, 24'h0);
            push_run(60);
            repeat (2) @(negedge mclk);
            rst_b = 1'b1;
            drain(3000, "restart_b");
            rst_b = 1'b0;

            // tiny raster: frame every 64 MCLK
            sel  = 2;
            hofs = 4'd0;
            vofs = 3'd0;
            repeat (2) @(negedge mclk);
            check_now("reset_c", obs, 24'h0);
            set_params(2, 8, 6, 6, 1, 4, 3, 3, 1);
            push_run(96);
            @(negedge mclk);
            rst_c = 1'b1;
            drain(3000, "run_c");
            rst_c = 1'b0;
            repeat (2) @(negedge mclk);
         end
      join_any
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
